// File: rtl/phase_seq_if.sv
// ============================================================================
// Module  : phase_seq_if
// Brief   : Valid/ready event channel carrying (phase, count) exit events.
// Rev     : 1.0
// ============================================================================
`default_nettype none

interface phase_seq_if #(
    parameter int WIDTH      = 8,
    parameter int NUM_PHASES = 3
);
    localparam int SEL_W = $clog2(NUM_PHASES);

    logic             OUT_VALID;
    logic             OUT_READY;
    logic [WIDTH-1:0] OUT_DATA;
    logic [SEL_W-1:0] OUT_PHASE;

    modport master (
        output OUT_VALID,
        output OUT_DATA,
        output OUT_PHASE,
        input  OUT_READY
    );

    modport slave (
        input  OUT_VALID,
        input  OUT_DATA,
        input  OUT_PHASE,
        output OUT_READY
    );
endinterface

`default_nettype wire

// File: rtl/phase_seq.sv
// ============================================================================
// Module  : phase_seq
// Brief   : Multi-phase counter sequencer with a programmable per-phase
//           step/threshold table; emits one (phase, count) event per phase
//           exit and stalls under backpressure. Option: PHASE_SEQ_SAT_EN
//           makes the counter add saturate instead of wrap.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module phase_seq #(
    parameter  int WIDTH      = 8,
    parameter  int NUM_PHASES = 3,
    localparam int SEL_W      = $clog2(NUM_PHASES)
) (
    input  wire logic             CLK,
    input  wire logic             RST,
    input  wire logic             START,
    input  wire logic             ABORT,
    input  wire logic             CFG_WE,
    input  wire logic [SEL_W-1:0] CFG_SEL,
    input  wire logic [WIDTH-1:0] CFG_STEP,
    input  wire logic [WIDTH-1:0] CFG_THRESH,
    phase_seq_if.master           evt,
    output logic                  BUSY,
    output logic [WIDTH-1:0]      CNT,
    output logic [SEL_W-1:0]      PHASE
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_STALL = 2'd2;

    localparam logic [SEL_W-1:0] LAST_PHASE = SEL_W'(NUM_PHASES - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] cnt;
    logic [SEL_W-1:0] phase;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [SEL_W-1:0] out_phase;

    logic [WIDTH-1:0] step_tbl   [NUM_PHASES];
    logic [WIDTH-1:0] thresh_tbl [NUM_PHASES];

    logic [WIDTH-1:0] cur_step;
    logic [WIDTH-1:0] cur_thresh;
    logic [WIDTH-1:0] cnt_add;
    logic             exit_hit;
    logic             out_ready;
    logic             take_exit;

    assign out_ready  = evt.OUT_READY;
    assign cur_step   = step_tbl[phase];
    assign cur_thresh = thresh_tbl[phase];
    assign exit_hit   = (cnt > cur_thresh);

`ifdef PHASE_SEQ_SAT_EN
    logic [WIDTH:0] cnt_sum;
    assign cnt_sum = {1'b0, cnt} + {1'b0, cur_step};
    assign cnt_add = cnt_sum[WIDTH] ? {WIDTH{1'b1}} : cnt_sum[WIDTH-1:0];
`else
    assign cnt_add = cnt + cur_step;
`endif

    // An exit proceeds from RUN unless an unaccepted event still occupies
    // the output; from STALL it proceeds as soon as the consumer is ready.
    assign take_exit = ((state == S_RUN) && exit_hit && !(out_valid && !out_ready))
                     || ((state == S_STALL) && out_ready);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= S_IDLE;
            cnt       <= '0;
            phase     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_phase <= '0;
        end else if (ABORT) begin
            state     <= S_IDLE;
            cnt       <= '0;
            phase     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_phase <= '0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (START) begin
                        state <= S_RUN;
                        cnt   <= '0;
                        phase <= '0;
                    end
                end
                S_RUN: begin
                    if (exit_hit && !take_exit) begin
                        state <= S_STALL;
                    end else if (!exit_hit) begin
                        cnt <= cnt_add;
                    end
                end
                S_STALL: begin
                    if (out_ready) begin
                        state <= S_RUN;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

            // Loading a new event overrides the acceptance clear above,
            // so back-to-back exits keep OUT_VALID high without a bubble.
            if (take_exit) begin
                out_data  <= cnt;
                out_phase <= phase;
                out_valid <= 1'b1;
                if (phase == LAST_PHASE) begin
                    phase <= '0;
                    cnt   <= '0;
                end else begin
                    phase <= phase + SEL_W'(1);
                    cnt   <= cnt_add;
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NUM_PHASES; i++) begin
                step_tbl[i]   <= WIDTH'(1);
                thresh_tbl[i] <= WIDTH'(7);
            end
        end else if (CFG_WE) begin
            // Selectors beyond the last phase match no entry and are dropped.
            for (int i = 0; i < NUM_PHASES; i++) begin
                if (CFG_SEL == SEL_W'(i)) begin
                    step_tbl[i]   <= CFG_STEP;
                    thresh_tbl[i] <= CFG_THRESH;
                end
            end
        end
    end

    assign evt.OUT_VALID = out_valid;
    assign evt.OUT_DATA  = out_data;
    assign evt.OUT_PHASE = out_phase;
    assign BUSY          = (state != S_IDLE);
    assign CNT           = cnt;
    assign PHASE         = phase;

endmodule

`default_nettype wire

// File: tb/tb_phase_seq.sv
// ============================================================================
// Module  : tb_phase_seq
// Brief   : Self-checking bench for phase_seq (default build: wrapping add).
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_phase_seq;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       START = 1'b0;
    logic       ABORT = 1'b0;
    logic       CFG_WE = 1'b0;
    logic [1:0] CFG_SEL = '0;
    logic [7:0] CFG_STEP = '0;
    logic [7:0] CFG_THRESH = '0;
    logic       BUSY;
    logic [7:0] CNT;
    logic [1:0] PHASE;

    phase_seq_if #(.WIDTH(8), .NUM_PHASES(3)) evt_if ();

    phase_seq #(.WIDTH(8), .NUM_PHASES(3)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .START      (START),
        .ABORT      (ABORT),
        .CFG_WE     (CFG_WE),
        .CFG_SEL    (CFG_SEL),
        .CFG_STEP   (CFG_STEP),
        .CFG_THRESH (CFG_THRESH),
        .evt        (evt_if),
        .BUSY       (BUSY),
        .CNT        (CNT),
        .PHASE      (PHASE)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic start;
        logic ready;
        int   cnt;
        int   ph;
        int   valid;
        int   data;
        int   oph;
        int   busy;
    } vec_t;

    vec_t vecs[13];

    // Reference model state: spec-level view with plain integers.
    int m_step[3];
    int m_thr[3];
    int m_mode;  // 0 idle, 1 counting, 2 stalled
    int m_cnt, m_ph, m_valid, m_data, m_oph;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input int e_cnt, input int e_ph,
                              input int e_valid, input int e_data, input int e_oph,
                              input int e_busy);
        chk({tag, ".CNT"},       int'(CNT),              e_cnt);
        chk({tag, ".PHASE"},     int'(PHASE),            e_ph);
        chk({tag, ".OUT_VALID"}, int'(evt_if.OUT_VALID), e_valid);
        chk({tag, ".OUT_DATA"},  int'(evt_if.OUT_DATA),  e_data);
        chk({tag, ".OUT_PHASE"}, int'(evt_if.OUT_PHASE), e_oph);
        chk({tag, ".BUSY"},      int'(BUSY),             e_busy);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic vec_t mk(input logic s, input logic r, input int c, input int p,
                                input int v, input int d, input int o, input int b);
        vec_t t;
        t.start = s; t.ready = r; t.cnt = c; t.ph = p;
        t.valid = v; t.data = d; t.oph = o; t.busy = b;
        return t;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_step[i] = 1;
            m_thr[i]  = 7;
        end
        m_mode = 0; m_cnt = 0; m_ph = 0; m_valid = 0; m_data = 0; m_oph = 0;
    endtask

    task automatic model_step(input bit start, input bit abort, input bit we,
                              input int sel, input int stp, input int thr,
                              input bit ready);
        int  nxt;
        bit  emit;
        int  old_valid;
        nxt       = (m_cnt + m_step[m_ph]) % 256;
        emit      = 1'b0;
        old_valid = m_valid;
        if (abort) begin
            m_mode = 0; m_cnt = 0; m_ph = 0; m_valid = 0; m_data = 0; m_oph = 0;
        end else begin
            if (old_valid == 1 && ready) m_valid = 0;
            if (m_mode == 0) begin
                if (start) begin
                    m_mode = 1; m_cnt = 0; m_ph = 0;
                end
            end else if (m_mode == 1) begin
                if (m_cnt > m_thr[m_ph]) begin
                    if (old_valid == 1 && !ready) m_mode = 2;
                    else emit = 1'b1;
                end else begin
                    m_cnt = nxt;
                end
            end else begin
                if (ready) begin
                    emit   = 1'b1;
                    m_mode = 1;
                end
            end
            if (emit) begin
                m_data  = m_cnt;
                m_oph   = m_ph;
                m_valid = 1;
                if (m_ph == 2) begin
                    m_ph = 0; m_cnt = 0;
                end else begin
                    m_ph  = m_ph + 1;
                    m_cnt = nxt;
                end
            end
        end
        if (we && sel < 3) begin
            m_step[sel] = stp;
            m_thr[sel]  = thr;
        end
    endtask

    initial begin
        // Default table, ready held high: count 0..8 then three back-to-back exits.
        vecs[0] = mk(1'b1, 1'b1, 0, 0, 0, 0, 0, 1);
        for (int i = 1; i <= 8; i++) vecs[i] = mk(1'b0, 1'b1, i, 0, 0, 0, 0, 1);
        vecs[9]  = mk(1'b0, 1'b1, 9,  1, 1, 8,  0, 1);
        vecs[10] = mk(1'b0, 1'b1, 10, 2, 1, 9,  1, 1);
        vecs[11] = mk(1'b0, 1'b1, 0,  0, 1, 10, 2, 1);
        vecs[12] = mk(1'b0, 1'b1, 1,  0, 0, 10, 2, 1);

        evt_if.OUT_READY = 1'b1;
        RST = 1'b1;
        repeat (2) tick();
        check_outs("reset", 0, 0, 0, 0, 0, 0);
        RST = 1'b0;
        tick();
        check_outs("idle", 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 13; i++) begin
            START            = vecs[i].start;
            evt_if.OUT_READY = vecs[i].ready;
            tick();
            check_outs($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].ph, vecs[i].valid,
                       vecs[i].data, vecs[i].oph, vecs[i].busy);
        end
        START = 1'b0;

        // Abort from RUN.
        ABORT = 1'b1;
        tick();
        check_outs("abort_run", 0, 0, 0, 0, 0, 0);
        ABORT = 1'b0;

        // Backpressure: stall on the second exit, then one-cycle ready.
        START = 1'b1; evt_if.OUT_READY = 1'b0;
        tick();
        START = 1'b0;
        repeat (8) tick();
        check_outs("bp_cnt8", 8, 0, 0, 0, 0, 1);
        tick();
        check_outs("bp_ev0", 9, 1, 1, 8, 0, 1);
        tick();
        check_outs("bp_stall1", 9, 1, 1, 8, 0, 1);
        tick();
        check_outs("bp_stall2", 9, 1, 1, 8, 0, 1);
        evt_if.OUT_READY = 1'b1;
        tick();
        check_outs("bp_release", 10, 2, 1, 9, 1, 1);
        evt_if.OUT_READY = 1'b0;
        tick();
        check_outs("bp_stall3", 10, 2, 1, 9, 1, 1);

        // Abort during STALL discards the pending event.
        ABORT = 1'b1;
        tick();
        check_outs("abort_stall", 0, 0, 0, 0, 0, 0);
        ABORT = 1'b0;
        START = 1'b1;
        tick();
        START = 1'b0;
        evt_if.OUT_READY = 1'b1;
        check_outs("restart", 0, 0, 0, 0, 0, 1);

        // Table write to phase 1 while in phase 0; out-of-range write ignored.
        CFG_WE = 1'b1; CFG_SEL = 2'd1; CFG_STEP = 8'd3; CFG_THRESH = 8'd20;
        tick();
        CFG_SEL = 2'd3; CFG_STEP = 8'd0; CFG_THRESH = 8'd0;
        tick();
        CFG_WE = 1'b0;
        check_outs("cfg_cnt2", 2, 0, 0, 0, 0, 1);
        repeat (6) tick();
        tick();
        check_outs("cfg_ph1", 9, 1, 1, 8, 0, 1);
        tick(); check_outs("cfg_12", 12, 1, 0, 8, 0, 1);
        tick(); check_outs("cfg_15", 15, 1, 0, 8, 0, 1);
        tick(); check_outs("cfg_18", 18, 1, 0, 8, 0, 1);
        tick(); check_outs("cfg_21", 21, 1, 0, 8, 0, 1);
        tick(); check_outs("cfg_exit1", 24, 2, 1, 21, 1, 1);
        tick(); check_outs("cfg_exit2", 0, 0, 1, 24, 2, 1);

        // Wrap: thresh 255 never exits, add wraps modulo 256.
        ABORT = 1'b1; CFG_WE = 1'b1; CFG_SEL = 2'd0; CFG_STEP = 8'd100; CFG_THRESH = 8'd255;
        tick();
        ABORT = 1'b0; CFG_WE = 1'b0; START = 1'b1;
        tick();
        START = 1'b0;
        check_outs("wrap_0", 0, 0, 0, 0, 0, 1);
        tick(); check_outs("wrap_100", 100, 0, 0, 0, 0, 1);
        tick(); check_outs("wrap_200", 200, 0, 0, 0, 0, 1);
        tick(); check_outs("wrap_44", 44, 0, 0, 0, 0, 1);
        tick(); check_outs("wrap_144", 144, 0, 0, 0, 0, 1);
        tick(); check_outs("wrap_244", 244, 0, 0, 0, 0, 1);
        tick(); check_outs("wrap_88", 88, 0, 0, 0, 0, 1);

        // Asynchronous reset between edges; table returns to defaults.
        #2 RST = 1'b1;
        #1 check_outs("async_rst", 0, 0, 0, 0, 0, 0);
        RST = 1'b0;
        START = 1'b1;
        tick();
        START = 1'b0;
        repeat (8) tick();
        check_outs("rst_dflt8", 8, 0, 0, 0, 0, 1);
        tick();
        check_outs("rst_dflt_ev", 9, 1, 1, 8, 0, 1);

        // Randomised run against the reference model.
        RST = 1'b1;
        #1 RST = 1'b0;
        model_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit r_start, r_abort, r_we, r_ready;
            int r_sel, r_stp, r_thr;
            r_start = ($urandom_range(0, 9) == 0);
            r_abort = ($urandom_range(0, 59) == 0);
            r_we    = ($urandom_range(0, 14) == 0);
            r_ready = ($urandom_range(0, 3) != 0);
            r_sel   = int'($urandom_range(0, 3));
            r_stp   = int'($urandom_range(0, 6));
            r_thr   = ($urandom_range(0, 5) == 0) ? 255 : int'($urandom_range(0, 30));
            START = r_start; ABORT = r_abort; CFG_WE = r_we;
            CFG_SEL = 2'(r_sel); CFG_STEP = 8'(r_stp); CFG_THRESH = 8'(r_thr);
            evt_if.OUT_READY = r_ready;
            model_step(r_start, r_abort, r_we, r_sel, r_stp, r_thr, r_ready);
            tick();
            check_outs($sformatf("rnd%0d", cyc), m_cnt, m_ph, m_valid, m_data, m_oph,
                       (m_mode != 0) ? 1 : 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/phase_seq.md
# phase_seq

Parametrised multi-phase counter sequencer: a configurable number of phases, each with its own programmable step and threshold, and a runtime-writable phase table. On leaving a phase it emits one (phase, count) event on a valid/ready output, and it stalls rather than drop an event. It sits in the control path as a timing/event generator feeding a downstream consumer that may apply backpressure.

## Interface
- `WIDTH`, 8: counter, step, threshold and output data width (4..32).
- `NUM_PHASES`, 3: number of phases (2..16).
- `SEL_W`, `$clog2(NUM_PHASES)`: phase index width (derived, not overridden).

Ports (clock is `CLK`; reset `RST` is asynchronous and active-high):
- `CLK` in 1: clock.
- `RST` in 1: asynchronous active-high reset.
- `START` in 1: pulse; IDLE -> RUN.
- `ABORT` in 1: return to IDLE; dominates all other inputs.
- `CFG_WE` in 1: phase-table write strobe.
- `CFG_SEL` in SEL_W: table entry to write.
- `CFG_STEP` in WIDTH: step value written.
- `CFG_THRESH` in WIDTH: threshold value written.
- `OUT_VALID` out 1: event pending.
- `OUT_READY` in 1: consumer accepts the event.
- `OUT_DATA` out WIDTH: count at the time of the phase exit.
- `OUT_PHASE` out SEL_W: phase that was exited.
- `BUSY` out 1: state is not IDLE.
- `CNT` out WIDTH: live counter value.
- `PHASE` out SEL_W: live phase index.

## Operation
- Reset values: state IDLE; `CNT`, `PHASE`, `OUT_DATA`, `OUT_PHASE` = 0; `OUT_VALID` and `BUSY` = 0. Every table entry resets to step = 1, thresh = 7.
- States:
  - IDLE: counter held. `START` -> RUN, with cnt = 0 and phase = 0.
  - RUN: counting. On an exit condition while `OUT_VALID && !OUT_READY` -> STALL.
  - STALL: cnt and phase frozen. When `OUT_READY` = 1, the pending exit is performed in that cycle and the state returns to RUN.
  - `ABORT` in any state -> IDLE: cnt = 0, phase = 0, `OUT_VALID` = 0, any pending event discarded.
- RUN, no exit: cnt <= cnt + step[phase].
- Exit condition: `cnt > thresh[phase]`, unsigned, evaluated on the current (pre-update) cnt.
- On exit, the event is registered: `OUT_DATA` <= cnt, `OUT_PHASE` <= phase, `OUT_VALID` <= 1.
  - Phase below NUM_PHASES-1: phase <= phase+1 and cnt <= cnt + step[phase].
  - Last phase: phase <= 0 and cnt <= 0.
- Output handshake:
  - `OUT_VALID` stays high and the event fields stay stable until `OUT_VALID && OUT_READY`.
  - Acceptance and a new exit in the same cycle: the new event is loaded and `OUT_VALID` stays 1; no bubble, no loss.
- Arithmetic: unsigned, modulo 2^WIDTH (see Configuration).
- thresh = 2^WIDTH-1 means the phase never exits; this is legal.
- Step 0 is legal; the counter holds.
- Table writes:
  - On `CFG_WE`, entry `CFG_SEL` takes `CFG_STEP`/`CFG_THRESH` at the clock edge.
  - A write to the active phase affects evaluation from the next cycle; the same-cycle compare uses the old values.
  - `CFG_SEL` >= NUM_PHASES is ignored.
  - Writes are accepted in every state.
- `START` while `BUSY` is ignored.

## Timing
- `START` sampled at edge n: RUN with cnt = 0 visible after edge n; `BUSY` = 1 from edge n.
- Exit condition true in cycle k: `OUT_VALID`/`OUT_DATA` are valid after edge k (1-cycle registered latency). The new phase and cnt are also visible after edge k.
- Consecutive exits are possible on back-to-back cycles. With `OUT_READY` held high, one event per cycle is sustained.
- `ABORT` at edge n: all outputs at reset values after edge n, except the table, which is kept.
- `RST` clears asynchronously, independent of `CLK`. Table entries return to defaults.

## Configuration
- `PHASE_SEQ_SAT_EN`
  - Defined: cnt + step clamps at 2^WIDTH-1; the counter never wraps.
  - Undefined: the add wraps modulo 2^WIDTH.
- The compare, handshake and state machine are identical in both builds.

## Test plan
- Defaults, `START` at cycle 0, `OUT_READY` = 1: cnt counts 0..8, then events (phase 0, 8), (1, 9), (2, 10) on three consecutive cycles. cnt then returns to 0, phase 0, and the sequence repeats.
- Backpressure: `OUT_READY` = 0 from the first event. State is STALL after the second exit condition, with cnt = 9 and phase = 1 frozen and `OUT_DATA` = 8 held. Raising `OUT_READY` for one cycle yields `OUT_DATA` = 9 with no bubble.
- Table write: CFG_SEL = 1, step = 3, thresh = 20 while in phase 0. Phase 1 then counts 9, 12, 15, 18, 21 and exits with `OUT_DATA` = 21. CFG_SEL = 3 writes are ignored.
- Wrap/saturate: WIDTH = 4, step = 5, thresh = 15. Without the macro, cnt cycles 0, 5, 10, 15, 4 and the phase never exits. With `PHASE_SEQ_SAT_EN`, cnt sticks at 15 and the phase never exits.
- `ABORT` during STALL with `OUT_VALID` = 1: the next cycle shows `OUT_VALID` = 0, IDLE, cnt = 0. A following `START` restarts at phase 0.
- `RST` asserted mid-RUN, asynchronous to `CLK`: outputs clear immediately and programmed table entries return to step 1 / thresh 7.
